// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller with frame-boundary value commit and dead time.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits above digit 0.
module display_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic                    load,
    input  logic                    blank,
    output logic                    busy,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
    logic                    busy_q, busy_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_q, frame_d;

    logic tick;
    logic boundary;
    logic [3:0] nibble;
    logic suppress;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick     = (count_q == CNT_LAST);
        boundary = tick && (idx_q == IDX_LAST);
        count_d  = tick ? '0 : count_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            S_DEAD:  if (count_q == DEAD_LAST) state_d = S_ON;
            S_ON:    if (tick) state_d = S_DEAD;
            default: state_d = S_DEAD;
        endcase

        // A load landing on the boundary edge bypasses the staging register entirely.
        disp_d  = disp_q;
        stage_d = stage_q;
        busy_d  = busy_q;
        if (boundary) begin
            if (load) begin
                disp_d = value_bcd;
                busy_d = 1'b0;
            end else if (busy_q) begin
                disp_d = stage_q;
                busy_d = 1'b0;
            end
        end else if (load) begin
            stage_d = value_bcd;
            busy_d  = 1'b1;
        end

        nibble   = disp_d[4*int'(idx_d) +: 4];
        suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d != '0) begin
            suppress = 1'b1;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j >= int'(idx_d) && disp_d[4*j +: 4] != 4'h0) suppress = 1'b0;
            end
        end
`endif

        // Segments follow the next digit even during dead time so they settle before enable.
        seg_d   = suppress ? 8'hFF : seg_code(nibble);
        en_d    = '1;
        if (state_d == S_ON && !blank) begin
            en_d = ~(NUM_DIGITS'(1) << idx_d);
        end
        frame_d = boundary;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_DEAD;
            count_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            stage_q <= '0;
            busy_q  <= 1'b0;
            seg_q   <= 8'hFF;
            en_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    assign busy       = busy_q;
    assign seg_out    = seg_q;
    assign digit_en   = en_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed plus random bench for display_scan_controller with a time-position reference model.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to check the leading-zero build.
module tb_display_scan_controller;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int DC    = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] value_bcd = 16'h0;
    logic        busy;
    logic [7:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference state: edges since reset release, displayed value, staged value.
    int          p = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_stage = 16'h0;
    logic        m_busy = 1'b0;

    logic [7:0] code_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_bcd (value_bcd),
        .load      (load),
        .blank     (blank),
        .busy      (busy),
        .seg_out   (seg_out),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, p);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic bl);
        int          idx;
        logic [7:0]  e_seg;
        logic [3:0]  e_en;
        logic        e_fd;
        load      = ld;
        value_bcd = v;
        blank     = bl;
        @(posedge clk);
        if (!rst_n) begin
            p       = 0;
            m_disp  = 16'h0;
            m_stage = 16'h0;
            m_busy  = 1'b0;
        end else begin
            p++;
            if (p % FRAME == 0) begin
                if (ld) begin
                    m_disp = v;
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    m_disp = m_stage;
                    m_busy = 1'b0;
                end
            end else if (ld) begin
                m_stage = v;
                m_busy  = 1'b1;
            end
        end
        if (p == 0) begin
            e_seg = 8'hFF;
            e_en  = 4'hF;
            e_fd  = 1'b0;
        end else begin
            idx   = (p / RD) % ND;
            e_seg = code_tab[m_disp[4*idx +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (m_disp >> (4*idx)) == 16'h0) e_seg = 8'hFF;
`endif
            e_en  = ((p % RD) >= DC && !bl) ? ~(4'b0001 << idx) : 4'hF;
            e_fd  = (p % FRAME == 0);
        end
        #1;
        check("seg_out",    16'(seg_out),    16'(e_seg));
        check("digit_en",   16'(digit_en),   16'(e_en));
        check("busy",       16'(busy),       16'(m_busy));
        check("frame_done", 16'(frame_done), 16'(e_fd));
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, value_bcd, blank);
    endtask

    // Advance until the edge count sits at the given position within the frame.
    task automatic run_until(input int res);
        for (int k = 0; k < FRAME; k++) begin
            if (p % FRAME == res) break;
            step(1'b0, value_bcd, blank);
        end
    endtask

    initial begin
        // Reset held three clocks; a load during reset must be ignored.
        rst_n = 1'b0;
        step(1'b1, 16'h9999, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        run(5);

        // Mid-frame load, committed at the next boundary and shown for a full frame.
        step(1'b1, 16'h1234, 1'b0);
        run(34);

        // Two loads before one boundary: last wins.
        run_until(3);
        step(1'b1, 16'h1111, 1'b0);
        run(4);
        step(1'b1, 16'h5678, 1'b0);
        run_until(0);
        run(16);

        // Load landing exactly on the boundary edge.
        run_until(15);
        step(1'b1, 16'h4321, 1'b0);
        run(16);

        // Non-decimal nibble, then a fully blanked frame.
        step(1'b1, 16'h00A0, 1'b0);
        run_until(0);
        run(16);
        for (int k = 0; k < FRAME; k++) step(1'b0, value_bcd, 1'b1);
        blank = 1'b0;
        run(16);

        // Reset mid-slot with a pending staged value.
        run_until(6);
        step(1'b1, 16'h9876, 1'b0);
        run(1);
        rst_n = 1'b0;
        step(1'b0, value_bcd, 1'b0);
        rst_n = 1'b1;
        run(20);

        // Leading-zero pattern.
        step(1'b1, 16'h0050, 1'b0);
        run_until(0);
        run(16);

        // Randomised traffic with occasional blanking and resets.
        for (int k = 0; k < 800; k++) begin
            logic        ld;
            logic        bl;
            logic [15:0] v;
            ld = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 15) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) v = v & 16'h00FF;
            rst_n = ($urandom_range(0, 199) != 0);
            step(ld, v, bl);
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
